// File: rtl/memc3_rst_supervisor_if.sv
// Reset/status handshake between the MCB reset supervisor and the memory clock/reset infrastructure.
interface memc3_rst_supervisor_if;
    logic       pll_lock;
    logic       calib_done;
    logic       retry_req;
    logic       mem_rst_n;
    logic       user_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [2:0] state;

    // master: the supervisor itself; slave: infrastructure and user side
    modport master (
        input  pll_lock, calib_done, retry_req,
        output mem_rst_n, user_rst, ready, fail, retry_count, state
    );

    modport slave (
        output pll_lock, calib_done, retry_req,
        input  mem_rst_n, user_rst, ready, fail, retry_count, state
    );
endinterface

// File: rtl/memc3_rst_supervisor.sv
// MCB reset supervisor: holds the memory PLL in reset, waits for lock and calibration with
// timeouts and bounded retries, then releases a delayed user reset.
//   state      | meaning
//   HOLD       | mem_rst_n low for HOLD_CYCLES
//   WAIT_LOCK  | waiting for synchronized PLL lock
//   WAIT_CALIB | waiting for calibration done, lock must stay up
//   RELEASE    | lock and calib stable for USER_DELAY before user reset drops
//   RUN        | user logic out of reset, only calib loss restarts
//   FAIL       | retries exhausted, waits for retry_req or sys_rst_n
module memc3_rst_supervisor #(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int CALIB_TIMEOUT = 65536,
    parameter int USER_DELAY    = 25,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 20
) (
    input logic                    clk0,
    input logic                    sys_rst_n,
    memc3_rst_supervisor_if.master ctl
);

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        WAIT_LOCK  = 3'd1,
        WAIT_CALIB = 3'd2,
        RELEASE    = 3'd3,
        RUN        = 3'd4,
        FAIL       = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CALIB_TC = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(USER_DELAY - 1);
    localparam logic [3:0]       MAX_RC   = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       retries_q, retries_d;
    logic             do_retry;

    logic lock_meta, lock_s;
    logic calib_meta, calib_s;

    logic mem_rst_n_q, user_rst_q, ready_q, fail_q;
    logic mem_rst_n_d, user_rst_d, ready_d, fail_d;

    always_ff @(posedge clk0) begin
        if (!sys_rst_n) begin
            lock_meta   <= 1'b0;
            lock_s      <= 1'b0;
            calib_meta  <= 1'b0;
            calib_s     <= 1'b0;
            state_q     <= HOLD;
            count_q     <= '0;
            retries_q   <= '0;
            mem_rst_n_q <= 1'b0;
            user_rst_q  <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            lock_meta   <= ctl.pll_lock;
            lock_s      <= lock_meta;
            calib_meta  <= ctl.calib_done;
            calib_s     <= calib_meta;
            state_q     <= state_d;
            count_q     <= count_d;
            retries_q   <= retries_d;
            mem_rst_n_q <= mem_rst_n_d;
            user_rst_q  <= user_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q + CNT_W'(1);
        retries_d = retries_q;
        do_retry  = 1'b0;

        case (state_q)
            HOLD: begin
                if (count_q == HOLD_TC) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                 state_d  = WAIT_CALIB;
                else if (count_q == LOCK_TC) do_retry = 1'b1;
            end
            WAIT_CALIB: begin
                if (!lock_s)                  do_retry = 1'b1;
                else if (calib_s)             state_d  = RELEASE;
                else if (count_q == CALIB_TC) do_retry = 1'b1;
            end
            RELEASE: begin
                if (!lock_s || !calib_s)      do_retry = 1'b1;
                else if (count_q == DELAY_TC) state_d  = RUN;
            end
            RUN: begin
                // PLL lock may drop during suspend; only calibration loss restarts the MCB
                count_d = '0;
                if (!calib_s) do_retry = 1'b1;
            end
            FAIL: begin
                count_d = '0;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        if (do_retry) begin
            if (retries_q == MAX_RC) begin
                state_d = FAIL;
            end else begin
                state_d = HOLD;
                if (retries_q != 4'hF) retries_d = retries_q + 4'd1;
            end
        end

        if (ctl.retry_req) begin
            state_d   = HOLD;
            retries_d = '0;
        end

        if (state_d != state_q || ctl.retry_req) count_d = '0;
    end

    // Outputs decode the next state so they switch on the same edge as the state register
    always_comb begin
        mem_rst_n_d = (state_d != HOLD);
        user_rst_d  = (state_d != RUN);
        ready_d     = (state_d == RUN);
        fail_d      = (state_d == FAIL);
    end

    assign ctl.mem_rst_n   = mem_rst_n_q;
    assign ctl.user_rst    = user_rst_q;
    assign ctl.ready       = ready_q;
    assign ctl.fail        = fail_q;
    assign ctl.retry_count = retries_q;
    assign ctl.state       = state_q;

endmodule

// File: doc/memc3_rst_supervisor.md
Name: memc3_rst_supervisor

Overview:
- Supervisory sequencer on the far side of the MCB clock/reset infrastructure interface.
- Drives the infrastructure's active-low reset request and consumes its PLL-lock indication plus the MCB calibration-done flag.
- Enforces timeouts with bounded automatic retries, then releases a delayed, registered user-logic reset.
- Runs on a free-running clock that is not derived from the memory PLL, so it keeps working while the PLL is held in reset.

Parameters:
HOLD_CYCLES, 16, cycles mem_rst_n is held low per attempt (>=2)
LOCK_TIMEOUT, 1024, max cycles in WAIT_LOCK before a retry
CALIB_TIMEOUT, 65536, max cycles in WAIT_CALIB before a retry
USER_DELAY, 25, cycles between calib seen and user_rst deassertion
MAX_RETRIES, 3, automatic retries before FAIL (0..15)
CNT_W, 20, shared cycle-counter width; must hold max(parameters)-1

Ports:
clk0  in  1  free-running clock, independent of the memory PLL
sys_rst_n  in  1  synchronous active-low reset
pll_lock  in  1  async PLL lock from the infrastructure block
calib_done  in  1  async MCB calibration-complete flag
retry_req  in  1  single-cycle pulse, synchronous to clk0; restarts the sequence and clears the retry count
mem_rst_n  out  1  active-low reset request to the infrastructure sys_rst_n input
user_rst  out  1  active-high reset to user logic in the memory domain
ready  out  1  high only in RUN
fail  out  1  high only in FAIL
retry_count  out  4  automatic retries taken since the last reset or retry_req
state  out  3  encoding: HOLD=0, WAIT_LOCK=1, WAIT_CALIB=2, RELEASE=3, RUN=4, FAIL=5

Behaviour:
- Single clock domain. Reset is synchronous and active-low on sys_rst_n.
- pll_lock and calib_done each pass through a 2-flop synchronizer (lock_s, calib_s); input-to-decision latency is 2 cycles.
- Synchronizer flops reset to 0.
- All outputs are registered Moore decodes of the state register and change on the same edge as the state.
- Reset values: state=HOLD, counter=0, retry_count=0, mem_rst_n=0, user_rst=1, ready=0, fail=0.
- Output decode:
  - mem_rst_n=0 only in HOLD.
  - user_rst=0 only in RUN.
  - ready = (state==RUN); fail = (state==FAIL).
- Single counter; it clears on every state change.
- HOLD:
  - Counter increments each cycle.
  - At count==HOLD_CYCLES-1 go to WAIT_LOCK, so mem_rst_n is low exactly HOLD_CYCLES cycles after reset release.
- WAIT_LOCK:
  - If lock_s=1, go to WAIT_CALIB.
  - Else if count==LOCK_TIMEOUT-1, RETRY.
- WAIT_CALIB (checks in priority order):
  - If lock_s=0, RETRY.
  - Else if calib_s=1, go to RELEASE.
  - Else if count==CALIB_TIMEOUT-1, RETRY.
- RELEASE:
  - If lock_s=0 or calib_s=0, RETRY.
  - Else at count==USER_DELAY-1 go to RUN.
- RUN:
  - lock_s loss is ignored; the PLL drops lock in suspend and must not reset the MCB.
  - calib_s=0 triggers RETRY.
- RETRY is an action, not a state:
  - If retry_count==MAX_RETRIES, go to FAIL and leave retry_count unchanged.
  - Otherwise increment retry_count (saturating at 15) and go to HOLD.
- FAIL is terminal. Only retry_req or sys_rst_n leaves it.
- retry_req has priority over every transition in every state: go to HOLD, clear counter and retry_count. In HOLD it restarts the hold count.
- sys_rst_n low on any cycle overrides all inputs and restores reset values on the next edge, including mid-sequence.
- Simultaneous events: if lock_s and a timeout both hit on the same cycle, the success transition wins (in WAIT_LOCK; WAIT_CALIB order as listed above).
- Counter never wraps; every state exits at or before its terminal count.
- MAX_RETRIES=0: the first timeout goes straight to FAIL.

Test Plan:
- Nominal:
  - Stimulus: release sys_rst_n at cycle 0; pll_lock=1 at cycle 30; calib_done=1 at cycle 200.
  - Response: mem_rst_n rises at cycle 16. WAIT_CALIB entered at cycle 32–33. RELEASE at cycle 202–203. user_rst falls and ready rises 25 cycles later. retry_count=0.
- Lock timeout:
  - Stimulus: pll_lock held 0.
  - Response: mem_rst_n pulses low for 16 cycles every 1040 cycles. retry_count steps 1,2,3. The fourth timeout enters FAIL with fail=1, mem_rst_n=1, user_rst=1.
- Recovery:
  - Stimulus: in FAIL, pulse retry_req; then give a healthy lock and calib.
  - Response: next cycle state=HOLD and retry_count=0; sequence completes to RUN.
- Lock loss:
  - Stimulus: drop pll_lock while in RELEASE.
  - Response: RETRY, with retry_count incrementing.
  - Stimulus: drop pll_lock while in RUN.
  - Response: stays in RUN, ready=1.
- Calibration loss:
  - Stimulus: drop calib_done in RUN.
  - Response: 2 cycles later state=HOLD, user_rst=1, ready=0, mem_rst_n=0.
- Mid-sequence reset:
  - Stimulus: assert sys_rst_n=0 for 1 cycle during WAIT_CALIB with retry_count=2.
  - Response: all reset values restored, retry_count=0.
  - Stimulus: same-cycle lock_s rise and LOCK_TIMEOUT expiry.
  - Response: goes to WAIT_CALIB, no retry.
